if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Small instruction-fetch FIFO between instruction memory and the IF/ID pipeline register.
- Stores {pc, instr} pairs from the fetch stage and presents the head entry to the IF/ID register.
- A pop handshake drives that register's write enable; when the queue is empty the output is a safe NOP.
- Flush discards all entries on branch redirect or trap.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
NOP_INSTR, 32'h0000_0013, instruction driven on o_pop_instr when empty (addi x0,x0,0)

Ports:
i_clk  input  1  clock; all state updates on posedge
i_rst  input  1  synchronous reset, active-high
i_push_valid  input  1  fetch stage offers an entry
o_push_ready  output  1  queue can accept an entry this cycle
i_push_pc  input  32  PC of offered instruction
i_push_instr  input  32  offered instruction word
o_pop_valid  output  1  head entry valid
i_pop_ready  input  1  IF/ID register accepts head (its write enable)
o_pop_pc  output  32  head PC
o_pop_instr  output  32  head instruction
i_flush  input  1  discard all contents
o_count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high, on i_rst.
- Reset values (applied at the posedge with i_rst=1):
  - count=0; rd_ptr=0; wr_ptr=0.
  - Resulting outputs: o_pop_valid=0, o_push_ready=1, o_count=0, o_pop_pc=32'h0, o_pop_instr=NOP_INSTR.
- Storage: DEPTH x 64-bit array, written only on push. Array contents need no reset.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. A separate counter gives occupancy.
- Push fires when i_push_valid && o_push_ready:
  - writes {pc, instr} at wr_ptr;
  - wr_ptr+1.
- o_push_ready = (count != DEPTH), computed combinationally from registered count.
  - No pass-through when full: a simultaneous pop does not make a full queue ready.
- Pop fires when o_pop_valid && i_pop_ready; rd_ptr+1.
- o_pop_valid = (count != 0).
- Output data when count != 0: o_pop_pc and o_pop_instr show the entry at rd_ptr, read combinationally from the array.
- Output data when count == 0: o_pop_pc=32'h0 and o_pop_instr=NOP_INSTR.
- Count update:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on push and pop together (legal when 0 < count < DEPTH).
- Latency: an entry pushed at cycle N is visible at the head at cycle N+1 at the earliest (without the optional feature).
- Ordering: strict FIFO; no reordering or dropping, except on flush.
- Flush (i_flush=1 at a posedge):
  - next state equals the reset state;
  - takes priority over a same-cycle push or pop: the pushed entry is dropped and the pop is not counted.
  - The fetch stage must re-present the redirect-target entry after flush.
- Priority order: i_rst > i_flush > push/pop.
- Reset asserted mid-stream: all entries are lost and the next cycle shows the reset values.
- Ignored inputs (no effect):
  - i_pop_ready while empty;
  - i_push_valid while full.
- No combinational path from i_pop_ready to o_push_ready.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: empty-queue bypass.
  - When count==0 and i_push_valid=1, o_pop_valid=1 combinationally, and o_pop_pc/o_pop_instr equal i_push_pc/i_push_instr the same cycle.
  - If i_pop_ready=1 in that cycle, the entry is consumed directly and not written to the array; count stays 0.
  - If i_pop_ready=0, the entry is stored normally.
  - While i_flush=1, bypass is suppressed and o_pop_valid=0.
- Undefined: no bypass. An empty queue shows o_pop_valid=0 regardless of push inputs, and the minimum push-to-head latency is 1 cycle.

Test Plan:
- Reset: hold i_rst=1 for 2 cycles with random inputs -> o_pop_valid=0, o_push_ready=1, o_count=0, o_pop_instr=32'h00000013, o_pop_pc=0.
- Fill and drain:
  - push PCs 0x100, 0x104, 0x108, 0x10C with instrs 0xA0..0xA3 and i_pop_ready=0 -> o_count=4 and o_push_ready=0;
  - a fifth push is ignored;
  - then i_pop_ready=1 -> heads pop in order 0x100..0x10C, o_count falls to 0 and the output returns to NOP.
- Simultaneous push/pop at count=2 for 10 cycles -> o_count stays 2, order is preserved, and pointer wrap past DEPTH-1 is exercised.
- Flush with i_push_valid=1 and i_pop_ready=1 at count=3 -> next cycle o_count=0 and o_pop_valid=0; the pushed entry never appears at the output.
- Empty push (bypass undefined): push PC 0x200, instr 0x00500093 at cycle N -> o_pop_valid=0 at N, 1 at N+1 with matching data.
- Empty push (FETCH_QUEUE_BYPASS_EN defined) -> o_pop_valid=1 at N with PC 0x200; with i_pop_ready=1, o_count remains 0.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue -- instruction-fetch FIFO between instruction memory and the
// IF/ID pipeline register.
//
// Holds {pc, instr} pairs offered by the fetch stage and presents the oldest
// one to IF/ID. The IF/ID write enable is the pop handshake. When the queue is
// empty the head shows pc=0 and a NOP so IF/ID never latches garbage. A flush
// (branch redirect / trap) returns the queue to its reset state.
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an entry pushed into an empty queue is presented at the head
//   in the same cycle. If the consumer takes it in that cycle it is never
//   written to the array.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push_valid/o_push_ready, i_push_pc, i_push_instr   fetch-side push
//   o_pop_valid/i_pop_ready, o_pop_pc, o_pop_instr       IF/ID-side pop
//   i_flush               discard all contents (drops same-cycle push/pop)
//   o_count               occupancy, 0..DEPTH
module if_fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push_valid,
    output logic                         o_push_ready,
    input  logic [31:0]                  i_push_pc,
    input  logic [31:0]                  i_push_instr,
    output logic                         o_pop_valid,
    input  logic                         i_pop_ready,
    output logic [31:0]                  o_pop_pc,
    output logic [31:0]                  o_pop_instr,
    input  logic                         i_flush,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [63:0]   mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic push_fire, pop_fire;
    logic byp_act;   // head is being driven straight from the push inputs
    logic byp_take;  // bypassed entry consumed this cycle, never stored
    logic push_st;   // push that lands in the array
    logic pop_mem;   // pop that retires an array entry
    logic wr_en;

    // Full queue never reports ready, even with a same-cycle pop, so ready
    // depends only on registered state.
    assign o_push_ready = (count_q != CW'(DEPTH));
    assign o_count      = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_act  = (count_q == '0) && i_push_valid && !i_flush;
    assign byp_take = byp_act && i_pop_ready;
`else
    assign byp_act  = 1'b0;
    assign byp_take = 1'b0;
`endif

    // Head presentation
    always_comb begin
        o_pop_valid = (count_q != '0);
        o_pop_pc    = 32'h0;
        o_pop_instr = NOP_INSTR;
        if (count_q != '0) begin
            {o_pop_pc, o_pop_instr} = mem_q[rd_ptr_q];
        end else if (byp_act) begin
            o_pop_valid = 1'b1;
            o_pop_pc    = i_push_pc;
            o_pop_instr = i_push_instr;
        end
    end

    assign push_fire = i_push_valid && o_push_ready;
    assign pop_fire  = o_pop_valid && i_pop_ready;
    assign push_st   = push_fire && !byp_take;
    assign pop_mem   = pop_fire && !byp_take;

    // Next state; flush collapses to the reset state and wins over push/pop.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        wr_en    = 1'b0;
        if (i_flush) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push_st) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_mem) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_st && !pop_mem) begin
                count_d = count_q + CW'(1);
            end else if (pop_mem && !push_st) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage carries no reset; validity is tracked by count/pointers alone.
    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            mem_q[wr_ptr_q] <= {i_push_pc, i_push_instr};
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_push_valid;
    logic        o_push_ready;
    logic [31:0] i_push_pc;
    logic [31:0] i_push_instr;
    logic        o_pop_valid;
    logic        i_pop_ready;
    logic [31:0] o_pop_pc;
    logic [31:0] o_pop_instr;
    logic        i_flush;
    logic [2:0]  o_count;

    int n_vec = 0;
    int n_err = 0;

    if_fetch_queue #(.DEPTH(4), .NOP_INSTR(NOP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push_valid (i_push_valid),
        .o_push_ready (o_push_ready),
        .i_push_pc    (i_push_pc),
        .i_push_instr (i_push_instr),
        .o_pop_valid  (o_pop_valid),
        .i_pop_ready  (i_pop_ready),
        .o_pop_pc     (o_pop_pc),
        .o_pop_instr  (o_pop_instr),
        .i_flush      (i_flush),
        .o_count      (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_push_valid = 0; i_pop_ready = 0; i_flush = 0;
        i_push_pc = 0; i_push_instr = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        i_push_valid = 1; i_push_pc = pc; i_push_instr = ins;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] hp;

    initial begin
        idle();
        i_rst = 1;
        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            i_push_valid = 1'($urandom); i_pop_ready = 1'($urandom);
            i_flush = 1'($urandom); i_push_pc = $urandom; i_push_instr = $urandom;
            tick();
        end
        idle();
        #1;
        chk("rst_valid", 32'(o_pop_valid), 0);
        chk("rst_ready", 32'(o_push_ready), 1);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_instr", o_pop_instr, NOP);
        chk("rst_pc",    o_pop_pc, 0);
        i_rst = 0;
        tick();

        // Pop-ready while empty is ignored
        i_pop_ready = 1; tick(); i_pop_ready = 0;
        chk("empty_pop_cnt", 32'(o_count), 0);

        // Fill
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(4*i), 32'hA0 + 32'(i));
            tick();
            if (i == 0) begin
                chk("fill_head_pc", o_pop_pc, 32'h100);
                chk("fill_head_in", o_pop_instr, 32'hA0);
            end
        end
        chk("full_count", 32'(o_count), 4);
        chk("full_ready", 32'(o_push_ready), 0);
        push(32'h110, 32'hA4);        // fifth push, ignored
        tick();
        chk("full_ign_cnt", 32'(o_count), 4);
        chk("full_ign_hd",  o_pop_pc, 32'h100);

        // Drain
        idle(); i_pop_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(o_pop_valid), 1);
            chk("drain_pc",    o_pop_pc, 32'h100 + 32'(4*i));
            chk("drain_instr", o_pop_instr, 32'hA0 + 32'(i));
            tick();
        end
        chk("drain_count", 32'(o_count), 0);
        chk("drain_valid0", 32'(o_pop_valid), 0);
        chk("drain_nop",   o_pop_instr, NOP);
        chk("drain_pc0",   o_pop_pc, 0);
        idle();

        // Simultaneous push/pop at count=2, pointers wrap
        push(32'h300, 32'hB00); tick();
        push(32'h304, 32'hB01); tick();
        exp_q.push_back(32'h300); exp_q.push_back(32'h304);
        chk("sim_pre_cnt", 32'(o_count), 2);
        for (int k = 0; k < 10; k++) begin
            push(32'h308 + 32'(4*k), 32'hB02 + 32'(k));
            i_pop_ready = 1;
            #1;
            hp = exp_q.pop_front();
            chk("sim_head_pc", o_pop_pc, hp);
            chk("sim_head_in", o_pop_instr, 32'hB00 + ((hp - 32'h300) >> 2));
            exp_q.push_back(32'h308 + 32'(4*k));
            tick();
            chk("sim_count", 32'(o_count), 2);
        end
        idle(); i_pop_ready = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            hp = exp_q.pop_front();
            chk("sim_tail_pc", o_pop_pc, hp);
            tick();
        end
        idle();
        chk("sim_end_cnt", 32'(o_count), 0);

        // Flush at count=3 with push and pop pending
        for (int i = 0; i < 3; i++) begin
            push(32'h400 + 32'(4*i), 32'hC0 + 32'(i)); tick();
        end
        chk("fl_pre_cnt", 32'(o_count), 3);
        push(32'h500, 32'hDEAD); i_pop_ready = 1; i_flush = 1;
        tick();
        idle();
        #1;
        chk("fl_count", 32'(o_count), 0);
        chk("fl_valid", 32'(o_pop_valid), 0);
        chk("fl_ready", 32'(o_push_ready), 1);
        tick();
        chk("fl_nodrop_v", 32'(o_pop_valid), 0);
        chk("fl_nodrop_pc", o_pop_pc, 0);

        // Empty push
`ifdef FETCH_QUEUE_BYPASS_EN
        push(32'h200, 32'h0050_0093); i_pop_ready = 1;
        #1;
        chk("byp_valid_N", 32'(o_pop_valid), 1);
        chk("byp_pc_N",    o_pop_pc, 32'h200);
        chk("byp_in_N",    o_pop_instr, 32'h0050_0093);
        tick();
        idle();
        chk("byp_count",   32'(o_count), 0);
        chk("byp_valid1",  32'(o_pop_valid), 0);
`else
        push(32'h200, 32'h0050_0093);
        #1;
        chk("ep_valid_N",  32'(o_pop_valid), 0);
        chk("ep_instr_N",  o_pop_instr, NOP);
        tick();
        idle();
        chk("ep_valid_N1", 32'(o_pop_valid), 1);
        chk("ep_pc_N1",    o_pop_pc, 32'h200);
        chk("ep_in_N1",    o_pop_instr, 32'h0050_0093);
        chk("ep_count",    32'(o_count), 1);
`endif

        // Mid-stream reset
        push(32'h600, 32'hE0); tick();
        push(32'h604, 32'hE1); i_rst = 1; tick();
        i_rst = 0; idle();
        #1;
        chk("mrst_count", 32'(o_count), 0);
        chk("mrst_valid", 32'(o_pop_valid), 0);
        chk("mrst_instr", o_pop_instr, NOP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
